// File: rtl/tetris_text_pkg.sv
// tetris_text_pkg: shared state encoding and glyph ROM geometry for the text line fetcher.
package tetris_text_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;
  localparam int GLYPH_ROWS = 64;
  localparam int GLYPH_CODE_W = 3;
  localparam int ROW_W = 6;
endpackage

// File: rtl/text_line_buffer.sv
// text_line_buffer: one ROM row per glyph slot, single write port and a single-bit read port.
module text_line_buffer
  import tetris_text_pkg::*;
#(
  parameter int width_p = 32,
  parameter int num_glyphs_p = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [GLYPH_CODE_W-1:0]    wr_slot_i,
  input  logic [width_p-1:0]         wr_data_i,
  input  logic [GLYPH_CODE_W-1:0]    rd_slot_i,
  input  logic [$clog2(width_p)-1:0] rd_col_i,
  output logic                       rd_bit_o
);
  logic [width_p-1:0] r_mem [num_glyphs_p];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_mem <= '{default: '0};
    else if (clr_i) r_mem <= '{default: '0};
    else if (we_i && int'(wr_slot_i) < num_glyphs_p) r_mem[wr_slot_i] <= wr_data_i;
  end
  assign rd_bit_o = (int'(rd_slot_i) < num_glyphs_p) ? r_mem[rd_slot_i][rd_col_i] : 1'b0;
endmodule

// File: rtl/text_line_fetcher.sv
// text_line_fetcher: fetches one glyph ROM row per character during hblank, then serialises it to pixels.
module text_line_fetcher
  import tetris_text_pkg::*;
#(
  parameter int width_p = 32,
  parameter int depth_p = 512,
  parameter int glyph_rows_p = GLYPH_ROWS,
  parameter int num_glyphs_p = 5,
  parameter int first_glyph_p = 0,
  parameter int x_origin_p = 160,
  parameter int y_origin_p = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       line_start_i,
  input  logic [9:0]                 line_y_i,
  input  logic                       pixel_valid_i,
  input  logic [9:0]                 pixel_x_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic                       pixel_o,
  output logic                       busy_o
);
  localparam int AW = $clog2(depth_p);
  localparam int CW = $clog2(width_p);
  localparam int KW = 4;
  state_t r_state, w_state_nxt;
  logic [KW-1:0] r_k;
  logic [ROW_W-1:0] r_row;
  logic r_hit, r_pixel;
  logic [AW-1:0] r_rom_addr;
  logic [width_p-1:0] r_fdata;
  logic [10:0] w_row, w_rel;
  logic w_row_hit, w_in_x, w_rd_bit, w_fetch_last;
  logic [GLYPH_CODE_W-1:0] w_code0, w_code_nxt, w_rd_slot;
  logic [CW-1:0] w_rd_col;
  // Signed 11-bit differences: a set MSB means the position lies before the origin.
  assign w_row = {1'b0, line_y_i} - 11'(y_origin_p);
  assign w_row_hit = !w_row[10] && (w_row < 11'(glyph_rows_p));
  assign w_rel = {1'b0, pixel_x_i} - 11'(x_origin_p);
  assign w_in_x = !w_rel[10] && (w_rel < 11'(num_glyphs_p * width_p));
  assign w_rd_slot = GLYPH_CODE_W'(w_rel / 11'(width_p));
  assign w_rd_col = CW'(width_p - 1) - CW'(w_rel % 11'(width_p));
  assign w_code0 = GLYPH_CODE_W'(first_glyph_p);
  assign w_code_nxt = w_code0 + GLYPH_CODE_W'(r_k) + GLYPH_CODE_W'(1);
  assign w_fetch_last = r_k == KW'(num_glyphs_p);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (line_start_i) w_state_nxt = w_row_hit ? FETCH : DRAW;
    else if (r_state == FETCH && w_fetch_last) w_state_nxt = DRAW;
  end
  // ROM data is registered one cycle, so slot n is written while address n+1 is on the bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_k <= '0;
      r_row <= '0;
      r_hit <= 1'b0;
      r_rom_addr <= '0;
      r_fdata <= '0;
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= (r_state == DRAW) && pixel_valid_i && r_hit && w_in_x && w_rd_bit;
      if (line_start_i) begin
        r_k <= '0;
        r_hit <= w_row_hit;
        r_row <= w_row[ROW_W-1:0];
        if (w_row_hit) r_rom_addr <= AW'({w_code0, w_row[ROW_W-1:0]});
      end else if (r_state == FETCH) begin
        r_k <= r_k + KW'(1);
        r_fdata <= rom_data_i;
        if (r_k < KW'(num_glyphs_p - 1)) r_rom_addr <= AW'({w_code_nxt, r_row});
      end
    end
  end
  text_line_buffer #(.width_p(width_p), .num_glyphs_p(num_glyphs_p)) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (line_start_i && !w_row_hit),
    .we_i      (r_state == FETCH && r_k != '0),
    .wr_slot_i (GLYPH_CODE_W'(r_k - KW'(1))),
    .wr_data_i (r_fdata),
    .rd_slot_i (w_rd_slot),
    .rd_col_i  (w_rd_col),
    .rd_bit_o  (w_rd_bit)
  );
  assign rom_addr_o = r_rom_addr;
  assign pixel_o = r_pixel;
  assign busy_o = r_state == FETCH;
endmodule

// File: tb/tb_text_line_fetcher.sv
// tb_text_line_fetcher: directed checks of fetch sequencing, restart, reset and pixel serialisation.
module tb_text_line_fetcher;
  import tetris_text_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic pixel_valid = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [8:0] rom_addr;
  logic [31:0] rom_data;
  logic pixel, busy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign rom_data = 32'hA500_0000 | 32'(rom_addr);
  text_line_fetcher u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .line_start_i  (line_start),
    .line_y_i      (line_y),
    .pixel_valid_i (pixel_valid),
    .pixel_x_i     (pixel_x),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .pixel_o       (pixel),
    .busy_o        (busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_line(input logic [9:0] y);
    line_y = y;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask
  task automatic pix(input string tag, input logic v, input logic [9:0] x, input logic exp);
    pixel_valid = v;
    pixel_x = x;
    step();
    chk(tag, 32'(pixel), 32'(exp));
    pixel_valid = 1'b0;
  endtask
  task automatic fetch_seq(input string tag, input int base);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_addr"}, 32'(rom_addr), 32'(base + 64 * (i < 5 ? i : 4)));
      step();
    end
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_draw"}, 32'(u_dut.r_state), 32'(DRAW));
  endtask
  initial begin
    #12;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(u_dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    // reset in the middle of a fetch
    start_line(10'd40);
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pixel", 32'(pixel), 32'd0);
    chk("mid_rst_state", 32'(u_dut.r_state), 32'(IDLE));
    chk("mid_rst_slot0", u_dut.u_buf.r_mem[0], 32'd0);
    step();
    rst_n = 1'b1;
    step();
    // full fetch of row 8
    start_line(10'd40);
    fetch_seq("row8", 8);
    chk("row8_slot0", u_dut.u_buf.r_mem[0], 32'hA500_0008);
    chk("row8_slot2", u_dut.u_buf.r_mem[2], 32'hA500_0088);
    chk("row8_slot4", u_dut.u_buf.r_mem[4], 32'hA500_0108);
    pix("px160", 1'b1, 10'd160, 1'b1);
    pix("px161", 1'b1, 10'd161, 1'b0);
    pix("px159", 1'b1, 10'd159, 1'b0);
    pix("px320", 1'b1, 10'd320, 1'b0);
    pix("px248", 1'b1, 10'd248, 1'b1);
    pix("px316", 1'b1, 10'd316, 1'b1);
    pix("px319", 1'b1, 10'd319, 1'b0);
    pix("px0", 1'b1, 10'd0, 1'b0);
    // rows above and below the text band
    start_line(10'd31);
    chk("y31_busy", 32'(busy), 32'd0);
    chk("y31_addr", 32'(rom_addr), 32'd264);
    chk("y31_slot2", u_dut.u_buf.r_mem[2], 32'd0);
    pix("y31_px160", 1'b1, 10'd160, 1'b0);
    pix("y31_px248", 1'b1, 10'd248, 1'b0);
    start_line(10'd96);
    chk("y96_busy", 32'(busy), 32'd0);
    chk("y96_addr", 32'(rom_addr), 32'd264);
    pix("y96_px160", 1'b1, 10'd160, 1'b0);
    chk("y96_busy2", 32'(busy), 32'd0);
    // last hit row and a restart during fetch
    start_line(10'd40);
    step();
    chk("restart_addr_pre", 32'(rom_addr), 32'd72);
    start_line(10'd95);
    fetch_seq("row63", 63);
    for (int i = 0; i < 5; i++)
      chk($sformatf("row63_slot%0d", i), u_dut.u_buf.r_mem[i], 32'hA500_0000 | 32'(63 + 64 * i));
    pix("px248_r63", 1'b1, 10'd248, 1'b1);
    // strobe low suppresses output
    pix("nv_px248", 1'b0, 10'd248, 1'b0);
    pix("nv_px200", 1'b0, 10'd200, 1'b0);
    pix("px_during_fetch_pre", 1'b1, 10'd160, 1'b1);
    line_y = 10'd40;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    pix("px_during_fetch", 1'b1, 10'd160, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
